// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operation handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ov;

    // Controller side: issues operations, observes status and result.
    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ov
    );

    // Subtractor side.
    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ov
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: diff = x - y - bi, borrow out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);
    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through one
// full-subtractor cell with a registered borrow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_e       state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic [WIDTH-1:0] diff_nxt;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             a_msb, b_msb;
    logic [WIDTH-1:0] d_q;
    logic             bout_q, ov_q;
    logic             cell_diff, cell_bo;
    logic             last_bit;

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bi   (brw),
        .diff (cell_diff),
        .bo   (cell_bo)
    );

    // Difference register after this bit is shifted in at the MSB end.
    assign diff_nxt = {cell_diff, diff_sr[WIDTH-1:1]};
    assign last_bit = (cnt == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift, borrow chain, bit count and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        brw   <= bus.bin;
                        cnt   <= '0;
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_nxt;
                    brw     <= cell_bo;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        // The bit just computed is the difference MSB.
                        d_q    <= diff_nxt;
                        bout_q <= cell_bo;
                        ov_q   <= (a_msb ^ b_msb) & (a_msb ^ cell_diff);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.ov   = ov_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vector table, handshake
// corner cases, mid-operation reset, and a full WIDTH=4 sweep.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ov;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one WIDTH=8 operation and return result, latency and busy count.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int lat, output int busyc);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        @(negedge clk);
        bus8.start = 1'b0;
        lat   = 0;
        busyc = bus8.busy ? 1 : 0;
        while (!bus8.done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus8.busy) busyc++;
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       output int lat);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.bin   = bin;
        @(negedge clk);
        bus4.start = 1'b0;
        lat = 0;
        while (!bus4.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, busyc, dones;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] ed;
        logic [4:0] full;
        logic       eo;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'h01, 1'b1, 8'hFD, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b1, 1'b0};

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_d",    32'(bus8.d),    32'd0);
        check("rst_bout", 32'(bus8.bout), 32'd0);
        check("rst_ov",   32'(bus8.ov),   32'd0);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, lat, busyc);
            check($sformatf("v%0d_lat", i),  32'(lat),       32'd8);
            check($sformatf("v%0d_busy", i), 32'(busyc),     32'd8);
            check($sformatf("v%0d_d", i),    32'(bus8.d),    32'(vecs[i].d));
            check($sformatf("v%0d_bout", i), 32'(bus8.bout), 32'(vecs[i].bout));
            check($sformatf("v%0d_ov", i),   32'(bus8.ov),   32'(vecs[i].ov));
        end

        // done is a single-cycle pulse
        @(negedge clk);
        check("done_pulse", 32'(bus8.done), 32'd0);

        // start during RUN is ignored
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 3;
        while (!bus8.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("ign_lat",  32'(lat),       32'd8);
        check("ign_d",    32'(bus8.d),    32'h0F);
        check("ign_bout", 32'(bus8.bout), 32'd0);
        check("ign_ov",   32'(bus8.ov),   32'd0);

        // Back-to-back: start asserted during the DONE cycle
        bus8.start = 1'b1; bus8.a = 8'h20; bus8.b = 8'h10; bus8.bin = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        check("b2b_busy", 32'(bus8.busy), 32'd1);
        check("b2b_hold", 32'(bus8.d),    32'h0F);
        lat = 0;
        while (!bus8.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat", 32'(lat),    32'd8);
        check("b2b_d",   32'(bus8.d), 32'h10);

        // Reset during an operation
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h11; bus8.bin = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(bus8.busy), 32'd0);
        check("mrst_done", 32'(bus8.done), 32'd0);
        check("mrst_d",    32'(bus8.d),    32'd0);
        check("mrst_bout", 32'(bus8.bout), 32'd0);
        check("mrst_ov",   32'(bus8.ov),   32'd0);
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus8.done) dones++;
            if (bus8.busy) dones++;
        end
        check("mrst_quiet", 32'(dones), 32'd0);
        rst_n = 1'b1;
        op8(8'h55, 8'h11, 1'b0, lat, busyc);
        check("post_lat",  32'(lat),       32'd8);
        check("post_d",    32'(bus8.d),    32'h44);
        check("post_bout", 32'(bus8.bout), 32'd0);
        check("post_ov",   32'(bus8.ov),   32'd0);

        // WIDTH=4 exhaustive sweep
        for (int i = 0; i < 512; i++) begin
            ea   = 4'(i >> 5);
            eb   = 4'(i >> 1);
            full = {1'b0, ea} - {1'b0, eb} - 5'(i & 1);
            ed   = full[3:0];
            eo   = (ea[3] ^ eb[3]) & (ea[3] ^ ed[3]);
            op4(ea, eb, 1'(i & 1), lat);
            check($sformatf("w4_%0d_lat", i),  32'(lat),       32'd4);
            check($sformatf("w4_%0d_d", i),    32'(bus4.d),    32'(ed));
            check($sformatf("w4_%0d_bout", i), 32'(bus4.bout), 32'(full[4]));
            check($sformatf("w4_%0d_ov", i),   32'(bus4.ov),   32'(eo));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
